// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared constants and types for the four-port packet arbiter
package pkt_arb_pkg;

  // Number of arbitrated input streams
  localparam int PORT_N = 4;

  // Width of a port index
  localparam int PTR_W = 2;

  // Arbiter FSM encoding: IDLE arbitrates, XFER forwards the granted packet
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational four-way round-robin pick starting after last_ptr
module rr_pick4
  import pkt_arb_pkg::*;
(
  input  logic [PORT_N-1:0] req,
  input  ptr_t              last_ptr,
  output logic [PORT_N-1:0] pick,
  output ptr_t              idx
);

  logic hit;
  ptr_t cand;

  // Walk from the lowest-priority offset (last_ptr itself) to the highest
  // (last_ptr+1); later matches overwrite earlier ones, so the nearest
  // requester after last_ptr wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = PORT_N; k >= 1; k--) begin
      cand = last_ptr + ptr_t'(k);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    pick = hit ? (PORT_N'(1) << idx) : '0;
  end

endmodule

// File: rtl/pkt_arb_4to1.sv
// rtl/pkt_arb_4to1.sv - packet round-robin arbiter, 4 streams to 1; PKT_ARB_CNT_EN adds per-port packet counters
module pkt_arb_4to1
  import pkt_arb_pkg::*;
#(
  parameter int DATA_W = 134,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORT_N-1:0]        in_valid,
  input  logic [PORT_N*DATA_W-1:0] in_data,
  input  logic [PORT_N-1:0]        in_eop,
  output logic [PORT_N-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_eop,
  input  logic                     out_ready,
  output logic [PTR_W-1:0]         out_port,
`ifdef PKT_ARB_CNT_EN
  output logic                     busy,
  input  logic                     cnt_clr,
  output logic [PORT_N*CNT_W-1:0]  pkt_cnt
`else
  output logic                     busy
`endif
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t            state;
  ptr_t              gnt_ptr;
  ptr_t              last_ptr;
  logic [PORT_N-1:0] pick;
  ptr_t              pick_idx;
  logic              xfer;
  logic              eop_acc;

  rr_pick4 u_pick (
    .req      (in_valid),
    .last_ptr (last_ptr),
    .pick     (pick),
    .idx      (pick_idx)
  );

  // Zero-latency data path: the granted port is muxed straight to the output
  // during XFER, and only the granted port sees out_ready as its accept.
  always_comb begin
    xfer      = (state == ST_XFER);
    out_data  = in_data[int'(gnt_ptr)*DATA_W +: DATA_W];
    out_valid = xfer & in_valid[gnt_ptr];
    out_eop   = xfer & in_eop[gnt_ptr];
    in_ready  = '0;
    if (xfer) begin
      in_ready[gnt_ptr] = out_ready;
    end
  end

  assign eop_acc  = out_valid & out_ready & out_eop;
  assign out_port = gnt_ptr;

  // Arbiter FSM: grant in IDLE, hold the grant through the accepted eop beat.
  // Stalls and valid gaps on the granted port never release the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_ptr  <= '0;
      last_ptr <= ptr_t'(PORT_N - 1);
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            gnt_ptr <= pick_idx;
            state   <= ST_XFER;
            busy    <= 1'b1;
          end
        end
        ST_XFER: begin
          if (eop_acc) begin
            last_ptr <= gnt_ptr;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PKT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [PORT_N];

  // Saturating per-port packet counters; a clear in the same cycle as an
  // increment takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORT_N; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < PORT_N; i++) cnt_q[i] <= '0;
    end else if (eop_acc && (cnt_q[gnt_ptr] != '1)) begin
      cnt_q[gnt_ptr] <= cnt_q[gnt_ptr] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < PORT_N; g++) begin : g_cnt_out
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pkt_arb_4to1.sv
// tb/tb_pkt_arb_4to1.sv - directed self-checking bench for pkt_arb_4to1
module tb_pkt_arb_4to1;

  localparam int DATA_W = 134;
  localparam int CNT_W  = 32;

  logic                 clk;
  logic                 rst;
  logic [3:0]           in_valid;
  logic [4*DATA_W-1:0]  in_data;
  logic [3:0]           in_eop;
  logic [3:0]           in_ready;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic                 out_eop;
  logic                 out_ready;
  logic [1:0]           out_port;
  logic                 busy;
`ifdef PKT_ARB_CNT_EN
  logic                 cnt_clr;
  logic [4*CNT_W-1:0]   pkt_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pkt_arb_4to1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .out_port  (out_port),
`ifdef PKT_ARB_CNT_EN
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .pkt_cnt   (pkt_cnt)
`else
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Beat payload tagged with port and beat number in several fields
  function automatic logic [DATA_W-1:0] mk(input int p, input int b);
    logic [DATA_W-1:0] d;
    d = '0;
    d[DATA_W-1 -: 8] = 8'(8'hA0 + p);
    d[15:0]          = 16'(p * 256 + b);
    d[70:63]         = 8'(b ^ 8'h5a);
    return d;
  endfunction

  // b holds one beat number per port, port p in b[4p+3:4p]
  task automatic drive(input logic [3:0] v, input logic [3:0] e, input logic [15:0] b, input logic rdy);
    in_valid  = v;
    in_eop    = e;
    out_ready = rdy;
    for (int p = 0; p < 4; p++) in_data[p*DATA_W +: DATA_W] = mk(p, int'(b[4*p +: 4]));
  endtask

  // One cycle: drive, check at the falling edge, advance past the next rising edge
  task automatic vec(input string tag, input logic [3:0] v, input logic [3:0] e, input logic [15:0] b,
                     input logic rdy, input logic ev, input logic [1:0] eport, input logic eeop,
                     input logic ebusy, input logic [3:0] erdy, input int ebeat);
    drive(v, e, b, rdy);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, ev);
    check({tag, "_port"},  out_port,  eport);
    check({tag, "_eop"},   out_eop,   eeop);
    check({tag, "_busy"},  busy,      ebusy);
    check({tag, "_ready"}, in_ready,  erdy);
    if (ev) check({tag, "_data"}, out_data, mk(int'(eport), ebeat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
`ifdef PKT_ARB_CNT_EN
    cnt_clr = 1'b0;
`endif
    drive(4'h0, 4'h0, 16'h0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_eop",   out_eop,   1'b0);
    check("rst_ready", in_ready,  4'h0);
    check("rst_busy",  busy,      1'b0);
    check("rst_port",  out_port,  2'd0);
`ifdef PKT_ARB_CNT_EN
    check("rst_cnt",   pkt_cnt,   '0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four ports request, 2-beat packets: grants 0,1,2,3,0 with one idle gap
    vec("t1c0",  4'hF, 4'h0, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t1c1",  4'hF, 4'h0, 16'h0000, 1, 1, 0, 0, 1, 4'h1, 0);
    vec("t1c2",  4'hF, 4'h1, 16'h0001, 1, 1, 0, 1, 1, 4'h1, 1);
    vec("t1c3",  4'hF, 4'h0, 16'h0002, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t1c4",  4'hF, 4'h0, 16'h0002, 1, 1, 1, 0, 1, 4'h2, 0);
    vec("t1c5",  4'hF, 4'h2, 16'h0012, 1, 1, 1, 1, 1, 4'h2, 1);
    vec("t1c6",  4'hF, 4'h0, 16'h0022, 1, 0, 1, 0, 0, 4'h0, 0);
    vec("t1c7",  4'hF, 4'h0, 16'h0022, 1, 1, 2, 0, 1, 4'h4, 0);
    vec("t1c8",  4'hF, 4'h4, 16'h0122, 1, 1, 2, 1, 1, 4'h4, 1);
    vec("t1c9",  4'hF, 4'h0, 16'h0222, 1, 0, 2, 0, 0, 4'h0, 0);
    vec("t1c10", 4'hF, 4'h0, 16'h0222, 1, 1, 3, 0, 1, 4'h8, 0);
    vec("t1c11", 4'hF, 4'h8, 16'h1222, 1, 1, 3, 1, 1, 4'h8, 1);
    vec("t1c12", 4'hF, 4'h0, 16'h2222, 1, 0, 3, 0, 0, 4'h0, 0);
    vec("t1c13", 4'hF, 4'h0, 16'h2222, 1, 1, 0, 0, 1, 4'h1, 2);
    vec("t1c14", 4'hF, 4'h1, 16'h2223, 1, 1, 0, 1, 1, 4'h1, 3);
    vec("t1c15", 4'h0, 4'h0, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);

    // Port 2 alone, three single-beat packets: valid pattern 1,0,1,0,1
    vec("t2c0",  4'h4, 4'h4, 16'h0400, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t2c1",  4'h4, 4'h4, 16'h0400, 1, 1, 2, 1, 1, 4'h4, 4);
    vec("t2c2",  4'h4, 4'h4, 16'h0500, 1, 0, 2, 0, 0, 4'h0, 0);
    vec("t2c3",  4'h4, 4'h4, 16'h0500, 1, 1, 2, 1, 1, 4'h4, 5);
    vec("t2c4",  4'h4, 4'h4, 16'h0600, 1, 0, 2, 0, 0, 4'h0, 0);
    vec("t2c5",  4'h4, 4'h4, 16'h0600, 1, 1, 2, 1, 1, 4'h4, 6);
    vec("t2c6",  4'h0, 4'h0, 16'h0000, 1, 0, 2, 0, 0, 4'h0, 0);

    // Port 1 stalled by out_ready low for three cycles on its second beat
    vec("t3c0",  4'h2, 4'h0, 16'h0000, 1, 0, 2, 0, 0, 4'h0, 0);
    vec("t3c1",  4'h2, 4'h0, 16'h0000, 1, 1, 1, 0, 1, 4'h2, 0);
    vec("t3c2",  4'h2, 4'h0, 16'h0010, 0, 1, 1, 0, 1, 4'h0, 1);
    vec("t3c3",  4'h2, 4'h0, 16'h0010, 0, 1, 1, 0, 1, 4'h0, 1);
    vec("t3c4",  4'h2, 4'h0, 16'h0010, 0, 1, 1, 0, 1, 4'h0, 1);
    vec("t3c5",  4'h2, 4'h0, 16'h0010, 1, 1, 1, 0, 1, 4'h2, 1);
    vec("t3c6",  4'h2, 4'h2, 16'h0020, 1, 1, 1, 1, 1, 4'h2, 2);
    vec("t3c7",  4'h0, 4'h0, 16'h0000, 1, 0, 1, 0, 0, 4'h0, 0);

    // Port 0 drops valid mid-packet while port 3 waits; grant stays on port 0
    vec("t4c0",  4'h1, 4'h0, 16'h0000, 1, 0, 1, 0, 0, 4'h0, 0);
    vec("t4c1",  4'h9, 4'h8, 16'h0000, 1, 1, 0, 0, 1, 4'h1, 0);
    vec("t4c2",  4'h8, 4'h8, 16'h0001, 1, 0, 0, 0, 1, 4'h1, 0);
    vec("t4c3",  4'h8, 4'h8, 16'h0001, 1, 0, 0, 0, 1, 4'h1, 0);
    vec("t4c4",  4'h9, 4'h9, 16'h0001, 1, 1, 0, 1, 1, 4'h1, 1);
    vec("t4c5",  4'h8, 4'h8, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t4c6",  4'h8, 4'h8, 16'h0000, 1, 1, 3, 1, 1, 4'h8, 0);
    vec("t4c7",  4'h0, 4'h0, 16'h0000, 1, 0, 3, 0, 0, 4'h0, 0);

    // Reset during beat 3 of a 5-beat packet from port 2
    vec("t5c0",  4'h4, 4'h0, 16'h0000, 1, 0, 3, 0, 0, 4'h0, 0);
    vec("t5c1",  4'h4, 4'h0, 16'h0000, 1, 1, 2, 0, 1, 4'h4, 0);
    vec("t5c2",  4'h4, 4'h0, 16'h0100, 1, 1, 2, 0, 1, 4'h4, 1);
    drive(4'h4, 4'h0, 16'h0200, 1'b1);
    @(negedge clk);
    check("t5_pre_busy", busy, 1'b1);
    check("t5_pre_data", out_data, mk(2, 2));
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_busy",  busy,      1'b0);
    check("t5_rst_ready", in_ready,  4'h0);
    check("t5_rst_port",  out_port,  2'd0);
    check("t5_rst_eop",   out_eop,   1'b0);
`ifdef PKT_ARB_CNT_EN
    check("t5_rst_cnt",   pkt_cnt,   '0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec("t5c3",  4'h5, 4'h5, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t5c4",  4'h5, 4'h5, 16'h0000, 1, 1, 0, 1, 1, 4'h1, 0);
    vec("t5c5",  4'h4, 4'h4, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);
    vec("t5c6",  4'h4, 4'h4, 16'h0000, 1, 1, 2, 1, 1, 4'h4, 0);
    vec("t5c7",  4'h0, 4'h0, 16'h0000, 1, 0, 2, 0, 0, 4'h0, 0);

`ifdef PKT_ARB_CNT_EN
    // Ports 0 and 3 send five single-beat packets each, alternating 3,0,3,...
    cnt_clr = 1'b1;
    vec("t6clr", 4'h0, 4'h0, 16'h0000, 1, 0, 2, 0, 0, 4'h0, 0);
    cnt_clr = 1'b0;
    check("t6_cleared", pkt_cnt, '0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1)
        vec("t6x", 4'h9, 4'h9, 16'h0000, 1, 1, ((i / 2) % 2 == 0) ? 2'd3 : 2'd0, 1, 1,
            ((i / 2) % 2 == 0) ? 4'h8 : 4'h1, 0);
      else
        vec("t6i", 4'h9, 4'h9, 16'h0000, 1, 0, (i == 0) ? 2'd2 : ((((i - 1) / 2) % 2 == 0) ? 2'd3 : 2'd0),
            0, 0, 4'h0, 0);
    end
    check("t6_cnt", pkt_cnt, {32'd5, 32'd0, 32'd0, 32'd5});
    vec("t6c0", 4'h8, 4'h8, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 0);
    cnt_clr = 1'b1;
    vec("t6c1", 4'h8, 4'h8, 16'h0000, 1, 1, 3, 1, 1, 4'h8, 0);
    cnt_clr = 1'b0;
    check("t6_clr_wins", pkt_cnt, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
